// File: rtl/bus_arbiter_pkg.sv
// Shared types for the two-master system-bus arbiter.
// Contents: address/data word types, arbiter FSM state enum, master id enum,
//           and a helper that maps a master id onto its one-hot grant bit.
package bus_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GNT0 = 2'd1,
      S_GNT1 = 2'd2
   } arb_state_e;

   // M0 = instruction-fetch cache, M1 = data cache
   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } master_id_e;

   // One-hot grant encoding {M1,M0}
   function automatic logic [1:0] grant_onehot(master_id_e id);
      return (id == M1) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// System-bus request/response bundle shared by the caches, the arbiter and BusCtrl.
// Signals: valid, wr, addr, dataM2S travel master->slave; ready, dataS2M travel slave->master.
// Modports: master drives the request side, slave drives ready/read-data.
interface bus_arbiter_if;
   import bus_arbiter_pkg::*;

   logic  valid;
   logic  wr;
   addr_t addr;
   data_t dataM2S;
   logic  ready;
   data_t dataS2M;

   modport master (
      output valid, wr, addr, dataM2S,
      input  ready, dataS2M
   );

   modport slave (
      input  valid, wr, addr, dataM2S,
      output ready, dataS2M
   );

endinterface

// File: rtl/bus_arbiter_pick.sv
// Arbitration rule: picks the winning master when the arbiter is idle.
// Ports: m0_valid/m1_valid requests, rr_ptr favoured master (round-robin),
//        prio_mode (0 = round-robin, 1 = fixed M1 priority), starve (M0 waited long enough), winner.
// Purely combinational; the caller only acts on winner when at least one valid is high.
module bus_arb_pick
   import bus_arbiter_pkg::*;
(
   input  logic       m0_valid,
   input  logic       m1_valid,
   input  master_id_e rr_ptr,
   input  logic       prio_mode,
   input  logic       starve,
   output master_id_e winner
);

   always_comb begin
      winner = M0;
      if (m0_valid && m1_valid) begin
         if (prio_mode) begin
            // M1 normally wins; a starved M0 takes this one arbitration
            winner = starve ? M0 : M1;
         end else begin
            winner = rr_ptr;
         end
      end else if (m1_valid) begin
         winner = M1;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the single BusCtrl slave between the I-cache (M0) and D-cache (M1) bus ports.
// Latency: slave valid follows a master's valid by 1 cycle from idle; completion hands over
//          back-to-back to the other master. Ports: clk, rst (sync, high), bM0If/bM1If (slave
//          modports), bSlvIf (master modport), oGrant one-hot {M1,M0}. Backpressure: slave ready
//          is routed only to the granted master; the other sees ready=0, dataS2M=0.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int P_PRIO_MODE = 0,
   parameter int P_MAX_WAIT  = 8
) (
   input  logic           clk,
   input  logic           rst,
   bus_arbiter_if.slave   bM0If,
   bus_arbiter_if.slave   bM1If,
   bus_arbiter_if.master  bSlvIf,
   output logic [1:0]     oGrant
);

   localparam int              CNT_W     = $clog2(P_MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(P_MAX_WAIT);
   localparam logic            PRIO_MODE = (P_PRIO_MODE != 0);

   arb_state_e        state;
   logic [1:0]        grant_q;
   master_id_e        rr_ptr;
   logic [CNT_W-1:0]  wait_cnt;
   logic              starve;
   master_id_e        winner;

   assign starve = PRIO_MODE && (wait_cnt == MAX_CNT);
   assign oGrant = grant_q;

   bus_arb_pick u_pick (
      .m0_valid  (bM0If.valid),
      .m1_valid  (bM1If.valid),
      .rr_ptr    (rr_ptr),
      .prio_mode (PRIO_MODE),
      .starve    (starve),
      .winner    (winner)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         grant_q  <= 2'b00;
         rr_ptr   <= M0;
         wait_cnt <= '0;
      end else begin
         // M0 waiting without a grant ages its counter; entering S_GNT0 below overrides this
         if (PRIO_MODE && bM0If.valid && (state != S_GNT0) && !starve) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end

         case (state)
            S_IDLE: begin
               if (bM0If.valid || bM1If.valid) begin
                  grant_q <= grant_onehot(winner);
                  if (winner == M0) begin
                     state    <= S_GNT0;
                     wait_cnt <= '0;
                  end else begin
                     state <= S_GNT1;
                  end
               end
            end

            S_GNT0: begin
               if (!bM0If.valid) begin
                  // abandoned request: no completion, pointer untouched
                  state   <= S_IDLE;
                  grant_q <= 2'b00;
               end else if (bSlvIf.ready) begin
                  rr_ptr <= M1;
                  if (bM1If.valid) begin
                     state   <= S_GNT1;
                     grant_q <= 2'b10;
                  end else begin
                     state   <= S_IDLE;
                     grant_q <= 2'b00;
                  end
               end
            end

            S_GNT1: begin
               if (!bM1If.valid) begin
                  state   <= S_IDLE;
                  grant_q <= 2'b00;
               end else if (bSlvIf.ready) begin
                  rr_ptr <= M0;
                  if (bM0If.valid) begin
                     state    <= S_GNT0;
                     grant_q  <= 2'b01;
                     wait_cnt <= '0;
                  end else begin
                     state   <= S_IDLE;
                     grant_q <= 2'b00;
                  end
               end
            end

            default: begin
               state   <= S_IDLE;
               grant_q <= 2'b00;
            end
         endcase
      end
   end

   // Request/response steering driven by the registered grant
   always_comb begin
      bSlvIf.valid   = 1'b0;
      bSlvIf.wr      = 1'b0;
      bSlvIf.addr    = '0;
      bSlvIf.dataM2S = '0;
      bM0If.ready    = 1'b0;
      bM0If.dataS2M  = '0;
      bM1If.ready    = 1'b0;
      bM1If.dataS2M  = '0;
      case (grant_q)
         2'b01: begin
            bSlvIf.valid   = bM0If.valid;
            bSlvIf.wr      = bM0If.wr;
            bSlvIf.addr    = bM0If.addr;
            bSlvIf.dataM2S = bM0If.dataM2S;
            bM0If.ready    = bSlvIf.ready;
            bM0If.dataS2M  = bSlvIf.dataS2M;
         end
         2'b10: begin
            bSlvIf.valid   = bM1If.valid;
            bSlvIf.wr      = bM1If.wr;
            bSlvIf.addr    = bM1If.addr;
            bSlvIf.dataM2S = bM1If.dataM2S;
            bM1If.ready    = bSlvIf.ready;
            bM1If.dataS2M  = bSlvIf.dataS2M;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a cycle table on a round-robin instance plus
// hand sequences for reset-in-grant, abandoned grant and the M0 starvation guard.
module tb_bus_arbiter;
   import bus_arbiter_pkg::*;

   logic clk;
   logic rst;
   logic [1:0] grant_a;
   logic [1:0] grant_b;

   int checks;
   int failures;

   bus_arbiter_if m0_a ();
   bus_arbiter_if m1_a ();
   bus_arbiter_if s_a ();
   bus_arbiter_if m0_b ();
   bus_arbiter_if m1_b ();
   bus_arbiter_if s_b ();

   bus_arbiter #(.P_PRIO_MODE(0), .P_MAX_WAIT(8)) u_dut0 (
      .clk(clk), .rst(rst), .bM0If(m0_a), .bM1If(m1_a), .bSlvIf(s_a), .oGrant(grant_a)
   );

   bus_arbiter #(.P_PRIO_MODE(1), .P_MAX_WAIT(4)) u_dut1 (
      .clk(clk), .rst(rst), .bM0If(m0_b), .bM1If(m1_b), .bSlvIf(s_b), .oGrant(grant_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        rst;
      logic        m0v;
      logic        m0w;
      logic [31:0] m0a;
      logic [31:0] m0d;
      logic        m1v;
      logic        m1w;
      logic [31:0] m1a;
      logic [31:0] m1d;
      logic        sr;
      logic [31:0] sd;
      logic [1:0]  g;
      logic        sv;
      logic        sw;
      logic [31:0] sa;
      logic [31:0] sdm;
      logic        r0;
      logic [31:0] d0;
      logic        r1;
      logic [31:0] d1;
   } vec_t;

   vec_t vecs[17];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic zero_a();
      m0_a.valid = 0; m0_a.wr = 0; m0_a.addr = 0; m0_a.dataM2S = 0;
      m1_a.valid = 0; m1_a.wr = 0; m1_a.addr = 0; m1_a.dataM2S = 0;
      s_a.ready = 0;  s_a.dataS2M = 0;
   endtask

   task automatic zero_b();
      m0_b.valid = 0; m0_b.wr = 0; m0_b.addr = 0; m0_b.dataM2S = 0;
      m1_b.valid = 0; m1_b.wr = 0; m1_b.addr = 0; m1_b.dataM2S = 0;
      s_b.ready = 0;  s_b.dataS2M = 0;
   endtask

   logic [133:0] act_v;
   logic [133:0] exp_v;

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      zero_a();
      zero_b();

      //  rst m0v w  m0a     m0d  m1v w  m1a      m1d   sr sd            g     sv sw sa       sdm    r0 d0            r1 d1
      vecs[0]  = '{0, 0,0,'h0,  'h0, 0,0,'h0,   'h0,  0,'h0,        2'b00,0,0,'h0,   'h0,  0,'h0,        0,'h0};
      vecs[1]  = '{0, 1,0,'h100,'h0, 0,0,'h0,   'h0,  0,'h0,        2'b00,0,0,'h0,   'h0,  0,'h0,        0,'h0};
      vecs[2]  = '{0, 1,0,'h100,'h0, 0,0,'h0,   'h0,  0,'h0,        2'b01,1,0,'h100, 'h0,  0,'h0,        0,'h0};
      vecs[3]  = '{0, 1,0,'h100,'h0, 0,0,'h0,   'h0,  1,'hDEADBEEF, 2'b01,1,0,'h100, 'h0,  1,'hDEADBEEF, 0,'h0};
      vecs[4]  = '{0, 0,0,'h0,  'h0, 0,0,'h0,   'h0,  0,'hDEADBEEF, 2'b00,0,0,'h0,   'h0,  0,'h0,        0,'h0};
      vecs[5]  = '{0, 0,0,'h0,  'h0, 1,1,'h7f00,'h1234,0,'h0,       2'b00,0,0,'h0,   'h0,  0,'h0,        0,'h0};
      vecs[6]  = '{0, 0,0,'h0,  'h0, 1,1,'h7f00,'h1234,0,'h0,       2'b10,1,1,'h7f00,'h1234,0,'h0,       0,'h0};
      vecs[7]  = '{0, 0,0,'h0,  'h0, 1,1,'h7f00,'h1234,1,'hCAFE0001,2'b10,1,1,'h7f00,'h1234,0,'h0,       1,'hCAFE0001};
      vecs[8]  = '{0, 0,0,'h0,  'h0, 0,0,'h0,   'h0,  0,'h0,        2'b00,0,0,'h0,   'h0,  0,'h0,        0,'h0};
      vecs[9]  = '{1, 0,0,'h0,  'h0, 0,0,'h0,   'h0,  0,'h0,        2'b00,0,0,'h0,   'h0,  0,'h0,        0,'h0};
      vecs[10] = '{0, 1,0,'h200,'h0, 1,1,'h300, 'h55, 1,'hA5A5A5A5, 2'b00,0,0,'h0,   'h0,  0,'h0,        0,'h0};
      vecs[11] = '{0, 1,0,'h200,'h0, 1,1,'h300, 'h55, 1,'hA5A5A5A5, 2'b01,1,0,'h200, 'h0,  1,'hA5A5A5A5, 0,'h0};
      vecs[12] = '{0, 1,0,'h200,'h0, 1,1,'h300, 'h55, 1,'hA5A5A5A5, 2'b10,1,1,'h300, 'h55, 0,'h0,        1,'hA5A5A5A5};
      vecs[13] = '{0, 1,0,'h200,'h0, 1,1,'h300, 'h55, 1,'hA5A5A5A5, 2'b01,1,0,'h200, 'h0,  1,'hA5A5A5A5, 0,'h0};
      vecs[14] = '{0, 1,0,'h200,'h0, 1,1,'h300, 'h55, 1,'hA5A5A5A5, 2'b10,1,1,'h300, 'h55, 0,'h0,        1,'hA5A5A5A5};
      vecs[15] = '{0, 0,0,'h0,  'h0, 0,0,'h0,   'h0,  0,'h0,        2'b01,0,0,'h0,   'h0,  0,'h0,        0,'h0};
      vecs[16] = '{0, 0,0,'h0,  'h0, 0,0,'h0,   'h0,  0,'h0,        2'b00,0,0,'h0,   'h0,  0,'h0,        0,'h0};

      step();
      step();
      rst = 1'b0;

      // Cycle table on the round-robin instance: inputs for a cycle, outputs seen in that cycle
      for (int i = 0; i < 17; i++) begin
         step();
         rst            = vecs[i].rst;
         m0_a.valid     = vecs[i].m0v;
         m0_a.wr        = vecs[i].m0w;
         m0_a.addr      = vecs[i].m0a;
         m0_a.dataM2S   = vecs[i].m0d;
         m1_a.valid     = vecs[i].m1v;
         m1_a.wr        = vecs[i].m1w;
         m1_a.addr      = vecs[i].m1a;
         m1_a.dataM2S   = vecs[i].m1d;
         s_a.ready      = vecs[i].sr;
         s_a.dataS2M    = vecs[i].sd;
         #3;
         act_v = {grant_a, s_a.valid, s_a.wr, s_a.addr, s_a.dataM2S,
                  m0_a.ready, m0_a.dataS2M, m1_a.ready, m1_a.dataS2M};
         exp_v = {vecs[i].g, vecs[i].sv, vecs[i].sw, vecs[i].sa, vecs[i].sdm,
                  vecs[i].r0, vecs[i].d0, vecs[i].r1, vecs[i].d1};
         checks++;
         if (act_v !== exp_v) begin
            failures++;
            $display("FAIL vec%0d: got %h expected %h", i, act_v, exp_v);
         end
      end

      // Reset during S_GNT1 with slave stalled; pointer had moved to favour M1
      step();
      rst = 1'b0; zero_a();
      m0_a.valid = 1; m0_a.addr = 'h10; s_a.ready = 1;
      step(); #3;
      chk("t5_m0_grant", {30'd0, grant_a}, 32'h1);
      chk("t5_m0_ready", {31'd0, m0_a.ready}, 32'h1);
      step();
      m0_a.valid = 0; m1_a.valid = 1; m1_a.addr = 'h20; s_a.ready = 0;
      step(); #3;
      chk("t5_m1_grant", {30'd0, grant_a}, 32'h2);
      chk("t5_m1_slv_valid", {31'd0, s_a.valid}, 32'h1);
      rst = 1; m0_a.valid = 1;
      step();
      rst = 0; #3;
      chk("t5_rst_grant", {30'd0, grant_a}, 32'h0);
      chk("t5_rst_slv_valid", {31'd0, s_a.valid}, 32'h0);
      step(); #3;
      chk("t5_after_rst_grant", {30'd0, grant_a}, 32'h1);
      chk("t5_after_rst_addr", s_a.addr, 32'h10);

      // Granted M0 abandons its request while M1 waits
      step();
      zero_a(); rst = 1;
      step();
      rst = 0;
      m0_a.valid = 1; m0_a.addr = 'h40;
      m1_a.valid = 1; m1_a.wr = 1; m1_a.addr = 'h80;
      step(); #3;
      chk("t6_m0_grant", {30'd0, grant_a}, 32'h1);
      m0_a.valid = 0; #1;
      chk("t6_drop_slv_valid", {31'd0, s_a.valid}, 32'h0);
      step(); #3;
      chk("t6_idle_grant", {30'd0, grant_a}, 32'h0);
      chk("t6_no_m0_ready", {31'd0, m0_a.ready}, 32'h0);
      step(); #3;
      chk("t6_m1_grant", {30'd0, grant_a}, 32'h2);
      chk("t6_m1_addr", s_a.addr, 32'h80);
      s_a.ready = 1; #1;
      chk("t6_m1_ready", {31'd0, m1_a.ready}, 32'h1);
      chk("t6_m0_ready_masked", {31'd0, m0_a.ready}, 32'h0);
      step();
      zero_a();

      // Fixed-priority instance: M1 re-requests after each abandoned grant until M0 starves
      rst = 1;
      step();
      rst = 0;
      m0_b.valid = 1; m0_b.addr = 'h500;
      m1_b.valid = 1; m1_b.addr = 'h600;
      step(); #3;
      chk("t3_g_a", {30'd0, grant_b}, 32'h2);
      chk("t3_cnt_a", 32'(u_dut1.wait_cnt), 32'd1);
      m1_b.valid = 0;
      step(); #3;
      chk("t3_g_b", {30'd0, grant_b}, 32'h0);
      chk("t3_cnt_b", 32'(u_dut1.wait_cnt), 32'd2);
      m1_b.valid = 1;
      step(); #3;
      chk("t3_g_c", {30'd0, grant_b}, 32'h2);
      chk("t3_cnt_c", 32'(u_dut1.wait_cnt), 32'd3);
      m1_b.valid = 0;
      step(); #3;
      chk("t3_g_d", {30'd0, grant_b}, 32'h0);
      chk("t3_cnt_d", 32'(u_dut1.wait_cnt), 32'd4);
      m1_b.valid = 1;
      step(); #3;
      chk("t3_g_starved", {30'd0, grant_b}, 32'h1);
      chk("t3_cnt_cleared", 32'(u_dut1.wait_cnt), 32'd0);
      chk("t3_slv_addr", s_b.addr, 32'h500);
      step();
      zero_b();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
